// File: rtl/axis_pkt_merger_pkg.sv
// rtl/axis_pkt_merger_pkg.sv - shared encodings for the two-input packet merger
package axis_pkt_merger_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND_AGG = 2'd1,
        SEND_BYP = 2'd2
    } state_t;

    typedef enum logic {
        SRC_AGG = 1'b0,
        SRC_BYP = 1'b1
    } src_t;

    function automatic src_t other_src(input src_t s);
        return (s == SRC_AGG) ? SRC_BYP : SRC_AGG;
    endfunction

endpackage

// File: rtl/axis_pkt_merger_if.sv
// rtl/axis_pkt_merger_if.sv - stream bundle with master/slave views
interface axis_pkt_merger_if #(
    parameter int DW  = 256,
    parameter int TUW = 128
) ();
    logic [DW-1:0]   tdata;
    logic [DW/8-1:0] tkeep;
    logic [TUW-1:0]  tuser;
    logic            tvalid;
    logic            tlast;
    logic            tready;

    modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
    modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_pkt_merger_skid_buf.sv
// rtl/axis_pkt_merger_skid_buf.sv - 2-entry register skid buffer with registered in_ready
module axis_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);
    logic [WIDTH-1:0] skid_data;
    logic             skid_valid;

    // The skid entry only fills while the output entry is stalled, so it
    // doubles as the "both entries full" flag and in_ready comes from a flop.
    assign in_ready = ~skid_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            skid_data  <= '0;
            skid_valid <= 1'b0;
        end else if (skid_valid) begin
            if (out_ready) begin
                out_data   <= skid_data;
                skid_valid <= 1'b0;
            end
        end else if (in_valid) begin
            if (!out_valid || out_ready) begin
                out_data  <= in_data;
                out_valid <= 1'b1;
            end else begin
                skid_data  <= in_data;
                skid_valid <= 1'b1;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_pkt_merger.sv
// rtl/axis_pkt_merger.sv - packet-atomic round-robin merge of aggregation and bypass streams
module axis_pkt_merger
    import axis_pkt_merger_pkg::*;
#(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int CNT_WIDTH          = 32
) (
    input  logic                 axis_aclk,
    input  logic                 axis_resetn,
    axis_pkt_merger_if.slave     s_axis_agg,
    axis_pkt_merger_if.slave     s_axis_byp,
    axis_pkt_merger_if.master    m_axis,
    output logic [CNT_WIDTH-1:0] pkt_agg_cnt,
    output logic [CNT_WIDTH-1:0] pkt_byp_cnt,
    input  logic                 clear_counters
);
    localparam int KW = C_AXIS_DATA_WIDTH / 8;
    localparam int BW = 1 + C_AXIS_TUSER_WIDTH + KW + C_AXIS_DATA_WIDTH;

    state_t          state, state_nxt;
    src_t            prio, prio_nxt;
    logic            agg_ready, byp_ready;
    logic            agg_done, byp_done;
    logic            buf_in_valid, buf_in_ready;
    logic [BW-1:0]   buf_in_data, buf_out_data;
    logic            buf_out_valid;

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state <= IDLE;
            prio  <= SRC_AGG;
        end else begin
            state <= state_nxt;
            prio  <= prio_nxt;
        end
    end

    // IDLE never raises tready, which costs one bubble per packet but keeps
    // the grant decision off the tvalid->tready path.
    always_comb begin
        state_nxt    = state;
        prio_nxt     = prio;
        agg_ready    = 1'b0;
        byp_ready    = 1'b0;
        agg_done     = 1'b0;
        byp_done     = 1'b0;
        buf_in_valid = 1'b0;
        buf_in_data  = {s_axis_agg.tlast, s_axis_agg.tuser, s_axis_agg.tkeep, s_axis_agg.tdata};
        unique case (state)
            IDLE: begin
                if (s_axis_agg.tvalid && (!s_axis_byp.tvalid || prio == SRC_AGG))
                    state_nxt = SEND_AGG;
                else if (s_axis_byp.tvalid)
                    state_nxt = SEND_BYP;
            end
            SEND_AGG: begin
                agg_ready    = buf_in_ready;
                buf_in_valid = s_axis_agg.tvalid;
                if (s_axis_agg.tvalid && buf_in_ready && s_axis_agg.tlast) begin
                    agg_done  = 1'b1;
                    state_nxt = IDLE;
                    prio_nxt  = other_src(SRC_AGG);
                end
            end
            SEND_BYP: begin
                byp_ready    = buf_in_ready;
                buf_in_valid = s_axis_byp.tvalid;
                buf_in_data  = {s_axis_byp.tlast, s_axis_byp.tuser, s_axis_byp.tkeep, s_axis_byp.tdata};
                if (s_axis_byp.tvalid && buf_in_ready && s_axis_byp.tlast) begin
                    byp_done  = 1'b1;
                    state_nxt = IDLE;
                    prio_nxt  = other_src(SRC_BYP);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign s_axis_agg.tready = agg_ready;
    assign s_axis_byp.tready = byp_ready;

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            pkt_agg_cnt <= '0;
            pkt_byp_cnt <= '0;
        end else if (clear_counters) begin
            pkt_agg_cnt <= '0;
            pkt_byp_cnt <= '0;
        end else begin
            if (agg_done) pkt_agg_cnt <= pkt_agg_cnt + CNT_WIDTH'(1);
            if (byp_done) pkt_byp_cnt <= pkt_byp_cnt + CNT_WIDTH'(1);
        end
    end

    axis_skid_buf #(.WIDTH(BW)) u_skid (
        .clk       (axis_aclk),
        .rst_n     (axis_resetn),
        .in_data   (buf_in_data),
        .in_valid  (buf_in_valid),
        .in_ready  (buf_in_ready),
        .out_data  (buf_out_data),
        .out_valid (buf_out_valid),
        .out_ready (m_axis.tready)
    );

    assign {m_axis.tlast, m_axis.tuser, m_axis.tkeep, m_axis.tdata} = buf_out_data;
    assign m_axis.tvalid = buf_out_valid;

endmodule
